// File: rtl/multicycle_datapath.sv
// Multi-cycle RV64 integer datapath: FETCH/DECODE/EXECUTE/MEM/WB FSM over req/ready memories.
// Define MCDP_BRANCH_EN to decode and execute BEQ; otherwise BEQ is illegal.
module multicycle_datapath #(
  parameter int PC_W       = 9,
  parameter int INS_W      = 32,
  parameter int RF_ADDRESS = 5,
  parameter int DATA_W     = 64,
  parameter int DM_ADDRESS = 9,
  parameter int ALU_CC_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_ready,
  input  logic [INS_W-1:0]      imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DM_ADDRESS-1:0] dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  retire,
  output logic                  illegal,
  output logic [PC_W-1:0]       pc_out
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
`ifdef MCDP_BRANCH_EN
  localparam logic [6:0] OP_BR  = 7'b1100011;
`endif

  localparam logic [ALU_CC_W-1:0] ALU_AND = ALU_CC_W'(0);
  localparam logic [ALU_CC_W-1:0] ALU_OR  = ALU_CC_W'(1);
  localparam logic [ALU_CC_W-1:0] ALU_ADD = ALU_CC_W'(2);
  localparam logic [ALU_CC_W-1:0] ALU_SUB = ALU_CC_W'(6);
  localparam logic [ALU_CC_W-1:0] ALU_SLT = ALU_CC_W'(7);

  localparam int NREG = 2 ** RF_ADDRESS;

  state_t state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INS_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              illegal_q, illegal_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
`ifdef MCDP_BRANCH_EN
  logic [PC_W-1:0]   old_pc_q, old_pc_d;
  logic              is_beq;
`endif

  logic [DATA_W-1:0] rf_q [NREG];

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [RF_ADDRESS-1:0] rs1, rs2, rd;
  logic r_base, r_alt;
  logic is_r, is_addi, is_ld, is_sd, legal;
  logic [ALU_CC_W-1:0] alu_cc;
  logic [DATA_W-1:0] rs1_val, rs2_val, imm_sel;
  logic [DATA_W-1:0] alu_b, alu_res, wb_data;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7  = ir_q[31:25];
  assign rd  = RF_ADDRESS'(ir_q[11:7]);
  assign rs1 = RF_ADDRESS'(ir_q[19:15]);
  assign rs2 = RF_ADDRESS'(ir_q[24:20]);

  assign r_base = (opc == OP_R) && (f7 == 7'b0000000);
  assign r_alt  = (opc == OP_R) && (f7 == 7'b0100000);

  always_comb begin
    is_r    = 1'b0;
    is_addi = 1'b0;
    is_ld   = 1'b0;
    is_sd   = 1'b0;
`ifdef MCDP_BRANCH_EN
    is_beq  = 1'b0;
`endif
    alu_cc  = ALU_ADD;
    unique case (1'b1)
      r_base && f3 == 3'b000: is_r = 1'b1;
      r_alt && f3 == 3'b000: begin
        is_r = 1'b1; alu_cc = ALU_SUB;
      end
      r_base && f3 == 3'b111: begin
        is_r = 1'b1; alu_cc = ALU_AND;
      end
      r_base && f3 == 3'b110: begin
        is_r = 1'b1; alu_cc = ALU_OR;
      end
      r_base && f3 == 3'b010: begin
        is_r = 1'b1; alu_cc = ALU_SLT;
      end
      opc == OP_IMM && f3 == 3'b000: is_addi = 1'b1;
      opc == OP_LD && f3 == 3'b011: is_ld = 1'b1;
      opc == OP_ST && f3 == 3'b011: is_sd = 1'b1;
`ifdef MCDP_BRANCH_EN
      opc == OP_BR && f3 == 3'b000: begin
        is_beq = 1'b1; alu_cc = ALU_SUB;
      end
`endif
      default: ;
    endcase
  end

`ifdef MCDP_BRANCH_EN
  assign legal = is_r | is_addi | is_ld | is_sd | is_beq;
`else
  assign legal = is_r | is_addi | is_ld | is_sd;
`endif

  assign rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];

  always_comb begin
    imm_sel = {{(DATA_W-12){ir_q[31]}}, ir_q[31:20]};
    if (is_sd)
      imm_sel = {{(DATA_W-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
`ifdef MCDP_BRANCH_EN
    if (is_beq)
      imm_sel = {{(DATA_W-13){ir_q[31]}}, ir_q[31], ir_q[7],
                 ir_q[30:25], ir_q[11:8], 1'b0};
`endif
  end

  assign alu_b = (is_addi | is_ld | is_sd) ? imm_q : b_q;

  always_comb begin
    alu_res = '0;
    unique case (alu_cc)
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_ADD: alu_res = a_q + alu_b;
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}},
                          $signed(a_q) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end

  assign wb_data = is_ld ? mdr_q : aluout_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
`ifdef MCDP_BRANCH_EN
    old_pc_d  = old_pc_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ready) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(4);
          state_d = S_DECODE;
`ifdef MCDP_BRANCH_EN
          old_pc_d = pc_q;
`endif
        end
      end
      S_DECODE: begin
        a_d   = rs1_val;
        b_d   = rs2_val;
        imm_d = imm_sel;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        aluout_d = alu_res;
        state_d  = S_WB;
        if (is_ld || is_sd)
          state_d = S_MEM;
`ifdef MCDP_BRANCH_EN
        if (is_beq) begin
          if (a_q == b_q)
            pc_d = old_pc_q + imm_q[PC_W-1:0];
          state_d = S_FETCH;
          retire  = 1'b1;
        end
`endif
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ready) begin
          if (is_ld) begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase
  end

  // Requests are registered from the next state so ready never reaches req combinationally.
  assign imem_req_d = (state_d == S_FETCH);
  assign dmem_req_d = (state_d == S_MEM);
  assign dmem_we_d  = (state_d == S_MEM) && is_sd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      aluout_q   <= '0;
      mdr_q      <= '0;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
`ifdef MCDP_BRANCH_EN
      old_pc_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      aluout_q   <= aluout_d;
      mdr_q      <= mdr_d;
      illegal_q  <= illegal_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
`ifdef MCDP_BRANCH_EN
      old_pc_q   <= old_pc_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (state_q == S_WB && rd != '0) begin
      rf_q[rd] <= wb_data;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = aluout_q[DM_ADDRESS-1:0];
  assign dmem_wdata = b_q;
  assign illegal    = illegal_q;
  assign pc_out     = pc_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with wait-state memory models.
// Register values are observed through stores into the data memory model.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ready;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [8:0]  dmem_addr;
  logic [63:0] dmem_wdata, dmem_rdata;
  logic        retire, illegal;
  logic [8:0]  pc_out;

  localparam logic [63:0] PAT = 64'hDEAD_BEEF_CAFE_F00D;

  logic [31:0] imem [128];
  logic [63:0] st   [64];
  logic        st_v [64];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  int checks = 0, passes = 0, stab_err = 0;

  multicycle_datapath dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .retire(retire), .illegal(illegal), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_rd(input int i);
    return st_v[i] ? st[i] : PAT;
  endfunction

  assign imem_ready = imem_req && (icnt >= iwait);
  assign imem_rdata = imem[imem_addr[8:2]];
  assign dmem_ready = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = mem_rd(int'(dmem_addr[8:3]));

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (reset) begin
      for (int i = 0; i < 64; i++) st_v[i] <= 1'b0;
    end else if (dmem_req && dmem_ready && dmem_we) begin
      st[dmem_addr[8:3]]   <= dmem_wdata;
      st_v[dmem_addr[8:3]] <= 1'b1;
    end
  end

  // A pending request must stay asserted with unchanged address/data.
  logic        pr_rst = 1'b1, pi_req = 1'b0, pi_rdy = 1'b0;
  logic        pd_req = 1'b0, pd_rdy = 1'b0, pd_we = 1'b0;
  logic [8:0]  pi_addr = '0, pd_addr = '0;
  logic [63:0] pd_wd = '0;
  always @(posedge clk) begin
    if (!pr_rst && pi_req && !pi_rdy &&
        (!imem_req || imem_addr != pi_addr))
      stab_err <= stab_err + 1;
    if (!pr_rst && pd_req && !pd_rdy &&
        (!dmem_req || dmem_addr != pd_addr ||
         dmem_wdata != pd_wd || dmem_we != pd_we))
      stab_err <= stab_err + 1;
    pr_rst  <= reset;
    pi_req  <= imem_req;
    pi_rdy  <= imem_ready;
    pi_addr <= imem_addr;
    pd_req  <= dmem_req;
    pd_rdy  <= dmem_ready;
    pd_addr <= dmem_addr;
    pd_wd   <= dmem_wdata;
    pd_we   <= dmem_we;
  end

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    iwait = 0;
    dwait = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Counts cycles from the current negedge until n retire pulses; -1 on timeout.
  task automatic run_ret(input int n, input int maxc, output int cyc);
    int r;
    r = 0;
    cyc = 0;
    while (r < n && cyc < maxc) begin
      cyc++;
      if (retire) r++;
      if (r < n) @(negedge clk);
    end
    if (r < n) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) $display("FAIL rst_imem_req got %b exp 0", imem_req);
    else passes++;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0)
      $display("FAIL rst_dmem got req=%b we=%b exp 0 0", dmem_req, dmem_we);
    else passes++;
    checks++;
    if (retire !== 1'b0 || illegal !== 1'b0)
      $display("FAIL rst_flags got ret=%b ill=%b exp 0 0", retire, illegal);
    else passes++;
    checks++;
    if (pc_out !== 9'd0) $display("FAIL rst_pc got %0h exp 0", pc_out);
    else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 9'd0)
      $display("FAIL rst_first_fetch got req=%b addr=%0h exp 1 0", imem_req, imem_addr);
    else passes++;
  endtask

  task automatic test_addi();
    int cyc;
    clear_imem();
    imem[0] = 32'h00500093;
    imem[1] = 32'h00103023;
    do_reset();
    run_ret(1, 20, cyc);
    checks++;
    if (cyc !== 4) $display("FAIL addi_cycles got %0d exp 4", cyc);
    else passes++;
    checks++;
    if (pc_out !== 9'd4) $display("FAIL addi_pc got %0h exp 4", pc_out);
    else passes++;
    @(negedge clk);
    run_ret(1, 20, cyc);
    checks++;
    if (cyc !== 4) $display("FAIL sd_cycles got %0d exp 4", cyc);
    else passes++;
    @(negedge clk);
    checks++;
    if (mem_rd(0) !== 64'd5) $display("FAIL addi_x1 got %0h exp 5", mem_rd(0));
    else passes++;
  endtask

  task automatic test_alu();
    int cyc;
    clear_imem();
    imem[0]  = 32'hFFD00093;
    imem[1]  = 32'h00700113;
    imem[2]  = 32'h0020A1B3;
    imem[3]  = 32'h40208233;
    imem[4]  = 32'h0020E333;
    imem[5]  = 32'h0020F3B3;
    imem[6]  = 32'h00208433;
    imem[7]  = 32'h001124B3;
    imem[8]  = 32'h00303823;
    imem[9]  = 32'h00403C23;
    imem[10] = 32'h02603423;
    imem[11] = 32'h02703823;
    imem[12] = 32'h02803C23;
    imem[13] = 32'h04903023;
    do_reset();
    run_ret(14, 200, cyc);
    @(negedge clk);
    checks++;
    if (cyc !== 56) $display("FAIL back_to_back_cycles got %0d exp 56", cyc);
    else passes++;
    checks++;
    if (mem_rd(2) !== 64'd1) $display("FAIL slt_x3 got %0h exp 1", mem_rd(2));
    else passes++;
    checks++;
    if (mem_rd(3) !== 64'hFFFF_FFFF_FFFF_FFF6)
      $display("FAIL sub_x4 got %0h exp fffffffffffffff6", mem_rd(3));
    else passes++;
    checks++;
    if (mem_rd(5) !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL or_x6 got %0h exp ffffffffffffffff", mem_rd(5));
    else passes++;
    checks++;
    if (mem_rd(6) !== 64'd5) $display("FAIL and_x7 got %0h exp 5", mem_rd(6));
    else passes++;
    checks++;
    if (mem_rd(7) !== 64'd4) $display("FAIL add_x8 got %0h exp 4", mem_rd(7));
    else passes++;
    checks++;
    if (mem_rd(8) !== 64'd0) $display("FAIL slt_x9 got %0h exp 0", mem_rd(8));
    else passes++;
  endtask

  task automatic test_mem_wait();
    int cyc;
    clear_imem();
    imem[0] = 32'h00700113;
    imem[1] = 32'h00203423;
    imem[2] = 32'h00803283;
    imem[3] = 32'h02503023;
    do_reset();
    dwait = 3;
    run_ret(1, 20, cyc);
    @(negedge clk);
    run_ret(1, 40, cyc);
    checks++;
    if (cyc !== 7) $display("FAIL sd_wait_cycles got %0d exp 7", cyc);
    else passes++;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 9'd8)
      $display("FAIL sd_req got req=%b we=%b addr=%0h exp 1 1 8", dmem_req, dmem_we, dmem_addr);
    else passes++;
    checks++;
    if (dmem_wdata !== 64'd7) $display("FAIL sd_wdata got %0h exp 7", dmem_wdata);
    else passes++;
    @(negedge clk);
    run_ret(1, 40, cyc);
    checks++;
    if (cyc !== 8) $display("FAIL ld_wait_cycles got %0d exp 8", cyc);
    else passes++;
    @(negedge clk);
    iwait = 2;
    dwait = 0;
    run_ret(1, 40, cyc);
    checks++;
    if (cyc !== 6) $display("FAIL fetch_wait_cycles got %0d exp 6", cyc);
    else passes++;
    @(negedge clk);
    checks++;
    if (mem_rd(4) !== 64'd7) $display("FAIL ld_x5 got %0h exp 7", mem_rd(4));
    else passes++;
    checks++;
    if (stab_err !== 0) $display("FAIL req_stable got %0d exp 0", stab_err);
    else passes++;
  endtask

  task automatic test_branch();
`ifdef MCDP_BRANCH_EN
    int cyc;
    clear_imem();
    imem[0] = 32'h00100093;
    imem[1] = 32'h00200113;
    imem[2] = 32'hFE108EE3;
    do_reset();
    run_ret(2, 20, cyc);
    @(negedge clk);
    run_ret(1, 20, cyc);
    checks++;
    if (cyc !== 3) $display("FAIL beq_cycles got %0d exp 3", cyc);
    else passes++;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 9'd4)
      $display("FAIL beq_taken got req=%b addr=%0h exp 1 4", imem_req, imem_addr);
    else passes++;
    run_ret(2, 20, cyc);
    @(negedge clk);
    checks++;
    if (imem_addr !== 9'd4) $display("FAIL beq_loop got %0h exp 4", imem_addr);
    else passes++;
    imem[2] = 32'hFE208EE3;
    do_reset();
    run_ret(3, 30, cyc);
    @(negedge clk);
    checks++;
    if (imem_addr !== 9'd12) $display("FAIL beq_not_taken got %0h exp c", imem_addr);
    else passes++;
`else
    clear_imem();
    imem[0] = 32'hFE108EE3;
    do_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (illegal !== 1'b1) $display("FAIL beq_disabled_illegal got %b exp 1", illegal);
    else passes++;
    checks++;
    if (imem_req !== 1'b0) $display("FAIL beq_disabled_req got %b exp 0", imem_req);
    else passes++;
`endif
  endtask

  task automatic test_illegal();
    int cyc;
    int nreq;
    clear_imem();
    imem[0] = 32'h00500093;
    imem[1] = 32'hFFFFFFFF;
    do_reset();
    run_ret(1, 20, cyc);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0) $display("FAIL ill_early got %b exp 0", illegal);
    else passes++;
    @(negedge clk);
    checks++;
    if (illegal !== 1'b1) $display("FAIL ill_set got %b exp 1", illegal);
    else passes++;
    nreq = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req || dmem_req || retire) nreq++;
    end
    checks++;
    if (nreq !== 0) $display("FAIL ill_halt_activity got %0d exp 0", nreq);
    else passes++;
    checks++;
    if (illegal !== 1'b1) $display("FAIL ill_sticky got %b exp 1", illegal);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    clear_imem();
    imem[0] = 32'h00900013;
    imem[1] = 32'h00003023;
    do_reset();
    run_ret(1, 20, cyc);
    @(negedge clk);
    iwait = 5;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 9'd4)
      $display("FAIL mid_wait_req got req=%b addr=%0h exp 1 4", imem_req, imem_addr);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0)
      $display("FAIL mid_rst_reqs got i=%b d=%b we=%b exp 0 0 0", imem_req, dmem_req, dmem_we);
    else passes++;
    checks++;
    if (pc_out !== 9'd0 || imem_addr !== 9'd0)
      $display("FAIL mid_rst_pc got pc=%0h addr=%0h exp 0 0", pc_out, imem_addr);
    else passes++;
    checks++;
    if (retire !== 1'b0 || illegal !== 1'b0)
      $display("FAIL mid_rst_flags got ret=%b ill=%b exp 0 0", retire, illegal);
    else passes++;
    reset = 1'b0;
    iwait = 0;
    @(negedge clk);
    run_ret(2, 30, cyc);
    checks++;
    if (cyc !== 8) $display("FAIL mid_rerun_cycles got %0d exp 8", cyc);
    else passes++;
    @(negedge clk);
    checks++;
    if (mem_rd(0) !== 64'd0) $display("FAIL x0_zero got %0h exp 0", mem_rd(0));
    else passes++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu();
    test_mem_wait();
    test_branch();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
